fwrisc_mem_unit: RTL

- Load/store unit directly downstream of the exec stage's decoded memory operands (op, base, offset, store data, rd).
- Computes the effective byte address and drives the single-outstanding data bus (dvalid/dready).
- For stores: lane-aligns data and generates byte strobes.
- For loads: extracts and sign/zero-extends read data, then returns a register write-back with a one-cycle completion pulse.
- Detects misaligned accesses and reports them instead of issuing a bus cycle.

---
 rtl/fwrisc_mem_pkg.sv | 53 +++++
 rtl/fwrisc_mem_fmt.sv | 52 +++++
 rtl/fwrisc_mem_unit.sv | 122 ++++++++++++
 3 files changed

// File: rtl/fwrisc_mem_pkg.sv
// rtl/fwrisc_mem_pkg.sv - shared op/state types and decode helpers for the memory unit
package fwrisc_mem_pkg;

  typedef enum logic [3:0] {
    OP_LB      = 4'd0,
    OP_LH      = 4'd1,
    OP_LW      = 4'd2,
    OP_LBU     = 4'd3,
    OP_LHU     = 4'd4,
    OP_SB      = 4'd5,
    OP_SH      = 4'd6,
    OP_SW      = 4'd7,
    OP_NUM_MEM = 4'd8
  } mem_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUS  = 2'd1,
    DONE = 2'd2
  } mem_state_e;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } mem_size_e;

  function automatic logic is_store(input mem_op_e op);
    return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
  endfunction

  function automatic mem_size_e size(input mem_op_e op);
    case (op)
      OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
      OP_LH, OP_LHU, OP_SH: return SZ_HALF;
      default:              return SZ_WORD;
    endcase
  endfunction

  // Out-of-range op codes execute as a plain word load.
  function automatic mem_op_e legalize(input logic [3:0] raw);
    return raw[3] ? OP_LW : mem_op_e'(raw);
  endfunction

  function automatic logic is_misaligned(input mem_op_e op, input logic [1:0] ea_lo);
    case (size(op))
      SZ_HALF: return ea_lo[0];
      SZ_WORD: return (ea_lo != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/fwrisc_mem_fmt.sv
// rtl/fwrisc_mem_fmt.sv - combinational store lane/strobe formatter and load extractor
import fwrisc_mem_pkg::*;

module fwrisc_mem_fmt (
  input  mem_op_e     op_i,
  input  logic [1:0]  ea_lo_i,
  input  logic [31:0] stdata_i,
  input  logic [31:0] rdata_i,
  output logic [31:0] wdata_o,
  output logic [3:0]  wstb_o,
  output logic [31:0] ldata_o
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata_i[8*ea_lo_i +: 8];
  assign lane_h = ea_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];

  always_comb begin
    wdata_o = 32'h0;
    wstb_o  = 4'b0000;
    if (is_store(op_i)) begin
      case (size(op_i))
        SZ_BYTE: begin
          wdata_o = {4{stdata_i[7:0]}};
          wstb_o  = 4'b0001 << ea_lo_i;
        end
        SZ_HALF: begin
          wdata_o = {2{stdata_i[15:0]}};
          wstb_o  = ea_lo_i[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata_o = stdata_i;
          wstb_o  = 4'b1111;
        end
      endcase
    end
  end

  always_comb begin
    ldata_o = rdata_i;
    case (op_i)
      OP_LB:   ldata_o = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ldata_o = {24'h0, lane_b};
      OP_LH:   ldata_o = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ldata_o = {16'h0, lane_h};
      default: ldata_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/fwrisc_mem_unit.sv
// rtl/fwrisc_mem_unit.sv - single-outstanding load/store unit with misalignment detection
import fwrisc_mem_pkg::*;

module fwrisc_mem_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  input  logic [3:0]        req_op,
  input  logic [ADDR_W-1:0] req_base,
  input  logic [ADDR_W-1:0] req_off,
  input  logic [DATA_W-1:0] req_stdata,
  input  logic [5:0]        req_rd,
  output logic              done,
  output logic              misalign,
  output logic [ADDR_W-1:0] badaddr,
  output logic              rd_write,
  output logic [5:0]        rd_waddr,
  output logic [DATA_W-1:0] rd_wdata,
  output logic [ADDR_W-1:0] daddr,
  output logic              dvalid,
  output logic              dwrite,
  output logic [DATA_W-1:0] dwdata,
  output logic [3:0]        dwstb,
  input  logic [DATA_W-1:0] drdata,
  input  logic              dready
);

  mem_state_e        state_q, state_d;
  mem_op_e           op_q, op_d;
  logic [ADDR_W-1:0] ea_q, ea_d;
  logic [DATA_W-1:0] st_q, st_d;
  logic [5:0]        rd_q, rd_d;
  logic [DATA_W-1:0] ldata_q, ldata_d;
  logic              mis_q, mis_d;

  logic [ADDR_W-1:0] ea_acc;
  mem_op_e           op_acc;
  logic [DATA_W-1:0] fmt_wdata;
  logic [3:0]        fmt_wstb;
  logic [DATA_W-1:0] fmt_ldata;

  assign ea_acc = req_base + req_off;
  assign op_acc = legalize(req_op);

  fwrisc_mem_fmt u_fmt (
    .op_i     (op_q),
    .ea_lo_i  (ea_q[1:0]),
    .stdata_i (st_q),
    .rdata_i  (drdata),
    .wdata_o  (fmt_wdata),
    .wstb_o   (fmt_wstb),
    .ldata_o  (fmt_ldata)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      op_q    <= OP_LB;
      ea_q    <= '0;
      st_q    <= '0;
      rd_q    <= '0;
      ldata_q <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      ea_q    <= ea_d;
      st_q    <= st_d;
      rd_q    <= rd_d;
      ldata_q <= ldata_d;
      mis_q   <= mis_d;
    end
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    ea_d    = ea_q;
    st_d    = st_q;
    rd_d    = rd_q;
    ldata_d = ldata_q;
    mis_d   = mis_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = op_acc;
          ea_d    = ea_acc;
          st_d    = req_stdata;
          rd_d    = req_rd;
          mis_d   = is_misaligned(op_acc, ea_acc[1:0]);
          state_d = mis_d ? DONE : BUS;
        end
      end
      BUS: begin
        if (dready) begin
          ldata_d = fmt_ldata;
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Bus-side fields come straight from latched state so they hold for all of BUS.
  assign dvalid   = (state_q == BUS);
  assign daddr    = ea_q;
  assign dwrite   = dvalid && is_store(op_q);
  assign dwdata   = dvalid ? fmt_wdata : '0;
  assign dwstb    = dvalid ? fmt_wstb : 4'b0000;

  assign done     = (state_q == DONE);
  assign misalign = done && mis_q;
  assign badaddr  = misalign ? ea_q : '0;
  assign rd_write = done && !mis_q && !is_store(op_q) && (rd_q != 6'd0);
  assign rd_waddr = rd_q;
  assign rd_wdata = ldata_q;

endmodule
